button_debouncer: RTL and testbench

//  Cleans a raw, asynchronous, bouncing push-button/switch input into a stable
//  one-clock-domain level. Sits directly upstream of the level-to-pulse stage:
//  its 'level' output drives that stage's 'in', so one press yields one pulse.

---
 rtl/button_debouncer.sv | 115 +++++++++++
 tb/tb_button_debouncer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: an N-flop synchroniser feeding a consecutive-sample debounce FSM.
// Optional macro INVERT_INPUT_EN inverts the raw input for active-low keys.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic busy
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    logic                   x;
    logic                   s;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    state_t                 state;

`ifdef INVERT_INPUT_EN
    assign x = ~in;
`else
    assign x = in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], x};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // cnt counts samples of the candidate level already seen, so entering WAIT_* starts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HIGH;
                        level <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        busy  <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LOW;
                        level <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a run-length reference model predicts level/busy each edge,
// a monitor compares them against the DUT. Honours INVERT_INPUT_EN like the design.
module tb_button_debouncer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SYNC = 2;

`ifdef INVERT_INPUT_EN
    localparam logic PRESS   = 1'b0;
    localparam logic RELEASE = 1'b1;
`else
    localparam logic PRESS   = 1'b1;
    localparam logic RELEASE = 1'b0;
`endif

    typedef struct {
        logic level;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_r;
    logic level;
    logic busy;

    int   checks = 0;
    int   errors = 0;

    exp_t expq[$];
    logic xq[$];
    logic exp_level;
    int   run;

    button_debouncer #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_r),
        .level (level),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: s is the conditioned input delayed SYNC edges; level flips once s has
    // differed from it on DEB consecutive edges; busy means a differing run is in progress.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        logic s;
        if (rst) begin
            exp_level = 1'b0;
            run       = 0;
            xq.delete();
            for (int i = 0; i < int'(SYNC); i++) xq.push_back(1'b0);
            if (clk) begin
                e.level = 1'b0;
                e.busy  = 1'b0;
                expq.push_back(e);
            end
        end else begin
            s = xq.pop_front();
            xq.push_back(in_r ^ ~PRESS);
            if (s != exp_level) begin
                run++;
                if (run == int'(DEB)) begin
                    exp_level = s;
                    run       = 0;
                end
            end else begin
                run = 0;
            end
            e.level = exp_level;
            e.busy  = (run != 0);
            expq.push_back(e);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
        end else begin
            e = expq.pop_front();
            checks++;
            if (level !== e.level) begin
                errors++;
                $display("FAIL level at %0t: got %b expected %b", $time, level, e.level);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            in_r = v;
        end
    endtask

    task automatic mid_cycle_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset at %0t: level=%b busy=%b expected 0 0", $time, level, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic latency(input logic v, input logic target, input string name);
        int k;
        int got;
        @(negedge clk);
        in_r = v;
        got = -1;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (level === target) begin
                got = k;
                break;
            end
        end
        checks++;
        if (got != int'(SYNC + DEB)) begin
            errors++;
            $display("FAIL %s at %0t: edges=%0d expected %0d", name, $time, got, SYNC + DEB);
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_r = RELEASE;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        latency(PRESS, 1'b1, "press_latency");
        hold(PRESS, 4);
        latency(RELEASE, 1'b0, "release_latency");
        hold(RELEASE, 4);

        hold(PRESS, 3);
        hold(RELEASE, 1);
        hold(PRESS, 12);

        mid_cycle_reset();
        hold(RELEASE, 10);

        hold(PRESS, 1);
        hold(RELEASE, 20);

        hold(PRESS, 4);
        mid_cycle_reset();
        hold(PRESS, 10);
        hold(RELEASE, 10);

        for (int i = 0; i < 40; i++) hold(logic'(i[0]), 1);

        for (int i = 0; i < 300; i++) begin
            logic v;
            v = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) hold(v, int'($urandom_range(DEB + 2, 12)));
            else hold(v, int'($urandom_range(1, DEB)));
        end

        hold(RELEASE, 10);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
